// File: rtl/tinymind_pkg.sv
// rtl/tinymind_pkg.sv - shared tinymind constants, FSM encoding and width helper
package tinymind_pkg;

    localparam int NUM_INPUTS_DEF  = 4;
    localparam int NUM_NEURONS_DEF = 3;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_CLEAR_ENC = 3'd1;
    localparam logic [2:0] ST_MAC_ENC   = 3'd2;
    localparam logic [2:0] ST_ACT_ENC   = 3'd3;
    localparam logic [2:0] ST_WRITE_ENC = 3'd4;
    localparam logic [2:0] ST_DONE_ENC  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_CLEAR = ST_CLEAR_ENC,
        ST_MAC   = ST_MAC_ENC,
        ST_ACT   = ST_ACT_ENC,
        ST_WRITE = ST_WRITE_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/tinymind_layer_seq_if.sv
// rtl/tinymind_layer_seq_if.sv - layer sequencer control, datapath and result handshake bundle
interface tinymind_layer_seq_if #(
    parameter int IN_W  = 8,
    parameter int NRN_W = 8,
    parameter int WT_W  = 16
);
    logic             start;
    logic             busy;
    logic             done_r;
    logic             acc_clr;
    logic             mac_en;
    logic             bias_sel;
    logic [IN_W-1:0]  in_idx;
    logic [WT_W-1:0]  wt_addr;
    logic             act_en;
    logic [NRN_W-1:0] nrn_idx;
    logic             out_valid;
    logic             out_ready;

    // master: the sequencer; slave: controller plus datapath side
    modport master (
        input  start, out_ready,
        output busy, done_r, acc_clr, mac_en, bias_sel, in_idx,
               wt_addr, act_en, nrn_idx, out_valid
    );

    modport slave (
        output start, out_ready,
        input  busy, done_r, acc_clr, mac_en, bias_sel, in_idx,
               wt_addr, act_en, nrn_idx, out_valid
    );
endinterface

// File: rtl/tinymind_idx_counter.sv
// rtl/tinymind_idx_counter.sv - clear/increment index counter that saturates at LAST
module tinymind_idx_counter #(
    parameter int WIDTH = 8,
    parameter int LAST  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == WIDTH'(LAST));
    assign cnt_o  = cnt_q;

    // Clear wins over increment; the count holds at LAST instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !last_o) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/tinymind_layer_seq.sv
// rtl/tinymind_layer_seq.sv - Moore sequencer walking every neuron of one fully-connected layer
module tinymind_layer_seq
    import tinymind_pkg::*;
#(
    parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int IN_W        = 8,
    parameter int NRN_W       = 8,
    parameter int WT_W        = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    tinymind_layer_seq_if.master bus
);
    state_e           state_q, state_d;
    logic [WT_W-1:0]  wt_addr_q, wt_addr_d;

    logic             in_clr, in_inc, in_last;
    logic [IN_W-1:0]  in_cnt;
    logic             nrn_clr, nrn_inc, nrn_last;
    logic [NRN_W-1:0] nrn_cnt;

    tinymind_idx_counter #(.WIDTH(IN_W), .LAST(NUM_INPUTS)) u_in_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (in_clr),
        .inc_i  (in_inc),
        .cnt_o  (in_cnt),
        .last_o (in_last)
    );

    tinymind_idx_counter #(.WIDTH(NRN_W), .LAST(NUM_NEURONS - 1)) u_nrn_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (nrn_clr),
        .inc_i  (nrn_inc),
        .cnt_o  (nrn_cnt),
        .last_o (nrn_last)
    );

    // wt_addr advances on every MAC step, bias included, so the next neuron's
    // row starts exactly where the previous one ended.
    always_comb begin
        state_d   = state_q;
        wt_addr_d = wt_addr_q;
        in_clr    = 1'b1;
        in_inc    = 1'b0;
        nrn_clr   = 1'b0;
        nrn_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                nrn_clr   = 1'b1;
                wt_addr_d = '0;
                if (bus.start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_MAC;
            ST_MAC: begin
                in_clr    = in_last;
                in_inc    = 1'b1;
                wt_addr_d = wt_addr_q + WT_W'(1);
                if (in_last) begin
                    state_d = ST_ACT;
                end
            end
            ST_ACT: state_d = ST_WRITE;
            ST_WRITE: begin
                if (bus.out_ready) begin
                    if (nrn_last) begin
                        state_d = ST_DONE;
                    end else begin
                        nrn_inc = 1'b1;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_DONE: begin
                nrn_clr   = 1'b1;
                wt_addr_d = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.done_r    = (state_q == ST_DONE);
        bus.acc_clr   = (state_q == ST_CLEAR);
        bus.mac_en    = (state_q == ST_MAC);
        bus.bias_sel  = (state_q == ST_MAC) && in_last;
        bus.act_en    = (state_q == ST_ACT);
        bus.out_valid = (state_q == ST_WRITE);
        bus.in_idx    = in_cnt;
        bus.nrn_idx   = nrn_cnt;
        bus.wt_addr   = wt_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wt_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wt_addr_q <= wt_addr_d;
        end
    end
endmodule
